// File: rtl/tinyalu_if.sv
// Command/response bundle between a TinyALU driver and tinyalu_core.
// The driver holds start until it samples done; result is valid while done is high.
interface tinyalu_if;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  op;
  logic        start;
  logic        done;
  logic [15:0] result;
  logic        err;

  modport master (output A, B, op, start, input done, result, err);
  modport slave  (input A, B, op, start, output done, result, err);
endinterface

// File: rtl/tinyalu_core.sv
// TinyALU: single-cycle add/and/xor, multi-cycle multiply, one-cycle done/err pulse.
// A command held on start executes once; the core waits for start to drop before accepting another.
module tinyalu_core #(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic      clk,
  input  logic      reset_n,
  tinyalu_if.slave  bus
);

  localparam int unsigned OPD_W = 8;
  localparam int unsigned RES_W = 16;
  localparam int unsigned CNT_W = 3;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WAIT_LOW} state_e;

  state_e             state_q,  state_d;
  logic [OPD_W-1:0]   a_q,      a_d;
  logic [OPD_W-1:0]   b_q,      b_d;
  logic [2:0]         op_q,     op_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               done_q,   done_d;
  logic               err_q,    err_d;
  logic [RES_W-1:0]   result_q, result_d;

  // Next-state and output computation; done/err default low so they pulse for one cycle.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d  = bus.A;
          b_d  = bus.B;
          op_d = bus.op;
          if (bus.op == OP_MUL) begin
            state_d = MUL;
            // Counts down to zero so done lands MUL_LATENCY edges after capture.
            cnt_d   = CNT_W'(MUL_LATENCY - 1);
          end else if (bus.op != OP_NOP) begin
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        done_d  = 1'b1;
        state_d = WAIT_LOW;
        case (op_q)
          OP_ADD:  result_d = {7'b0, 9'(a_q) + 9'(b_q)};
          OP_AND:  result_d = {8'b0, a_q & b_q};
          OP_XOR:  result_d = {8'b0, a_q ^ b_q};
          default: begin
            result_d = '0;
            err_d    = 1'b1;
          end
        endcase
      end

      MUL: begin
        if (cnt_q == '0) begin
          done_d   = 1'b1;
          result_d = RES_W'(a_q) * RES_W'(b_q);
          state_d  = WAIT_LOW;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      WAIT_LOW: begin
        if (!bus.start) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_tinyalu_core.sv
// Directed, table-driven bench for tinyalu_core with hand sequences for no_op, reset and restart.
module tb_tinyalu_core;

  localparam int unsigned MUL_LAT = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  tinyalu_if bus ();

  tinyalu_core #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [15:0] res;
    logic        err;
    int          lat;
    int          hold;
    bit          drop;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one command, scrambles inputs after capture, measures latency and the done pulse.
  task automatic run_cmd(input vec_t v, input int idx);
    int cyc;
    @(negedge clk);
    bus.A = v.a; bus.B = v.b; bus.op = v.op; bus.start = 1'b1;
    @(negedge clk);
    bus.A = ~v.a; bus.B = 8'h5A; bus.op = 3'b001;
    if (v.drop) bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL vec%0d_timeout: got no done expected done within 20 cycles", idx);
    end else begin
      check($sformatf("vec%0d_latency", idx), 16'(cyc - 1), 16'(v.lat));
      check($sformatf("vec%0d_result", idx), bus.result, v.res);
      check($sformatf("vec%0d_err", idx), 16'(bus.err), 16'(v.err));
      @(negedge clk);
      check($sformatf("vec%0d_done_clear", idx), 16'(bus.done), 16'h0);
      check($sformatf("vec%0d_err_clear", idx), 16'(bus.err), 16'h0);
      check($sformatf("vec%0d_result_hold", idx), bus.result, v.res);
      for (int i = 0; i < v.hold; i++) begin
        @(negedge clk);
        check($sformatf("vec%0d_held_no_done", idx), 16'(bus.done), 16'h0);
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    //           a      b      op      res       err  lat      hold drop
    vecs[0] = '{8'hFF, 8'h01, 3'b001, 16'h0100, 1'b0, 1,       0, 1'b0};
    vecs[1] = '{8'hFF, 8'hFF, 3'b100, 16'hFE01, 1'b0, MUL_LAT, 0, 1'b0};
    vecs[2] = '{8'h12, 8'h34, 3'b111, 16'h0000, 1'b1, 1,       0, 1'b0};
    vecs[3] = '{8'hAA, 8'h0F, 3'b011, 16'h00A5, 1'b0, 1,       5, 1'b0};
    vecs[4] = '{8'hF0, 8'h3C, 3'b010, 16'h0030, 1'b0, 1,       0, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 3'b001, 16'h0080, 1'b0, 1,       0, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 3'b100, 16'h03A8, 1'b0, MUL_LAT, 2, 1'b1};
    vecs[7] = '{8'h55, 8'h66, 3'b101, 16'h0000, 1'b1, 1,       0, 1'b0};
    vecs[8] = '{8'h00, 8'hFF, 3'b100, 16'h0000, 1'b0, MUL_LAT, 0, 1'b0};

    bus.A = '0; bus.B = '0; bus.op = '0; bus.start = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_done", 16'(bus.done), 16'h0);
    check("reset_err", 16'(bus.err), 16'h0);
    check("reset_result", bus.result, 16'h0000);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_cmd(vecs[i], i);

    // no_op held for one cycle must not complete; a following and_op must.
    @(negedge clk);
    bus.A = 8'h11; bus.B = 8'h22; bus.op = 3'b000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("noop_no_done", 16'(bus.done), 16'h0);
      @(negedge clk);
    end
    run_cmd(vecs[4], 40);

    // Leave a nonzero result, then reset one cycle into a multiply.
    run_cmd(vecs[1], 41);
    @(negedge clk);
    bus.A = 8'hFF; bus.B = 8'hFF; bus.op = 3'b100; bus.start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midmul_reset_done", 16'(bus.done), 16'h0);
    check("midmul_reset_err", 16'(bus.err), 16'h0);
    check("midmul_reset_result", bus.result, 16'h0000);
    bus.start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midmul_no_done_after", 16'(bus.done), 16'h0);
    end

    // start already high when reset releases is captured on the first edge.
    reset_n = 1'b0;
    bus.A = 8'h01; bus.B = 8'h02; bus.op = 3'b001; bus.start = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("release_capture_no_done_yet", 16'(bus.done), 16'h0);
    @(negedge clk);
    check("release_capture_done", 16'(bus.done), 16'h1);
    check("release_capture_result", bus.result, 16'h0003);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
